// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO with registered read data and full/empty flow control.
// Defining SYNC_FIFO_STATUS_EN adds the count, overflow and underflow status outputs.
module sync_fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
`ifdef SYNC_FIFO_STATUS_EN
    ,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] wptr_nxt;
    logic [ADDR_WIDTH:0] rptr_nxt;
    logic                wr_acc;
    logic                rd_acc;

    // Pointer MSB is the wrap bit: equal low bits with differing wrap bits means a full lap ahead.
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        rd_acc   = rd_en && !empty;
        // A read in the same cycle frees a slot, so a write at full is still accepted.
        wr_acc   = wr_en && (!full || rd_acc);
        if (wr_acc) begin
            wptr_nxt = wptr + PTR_ONE;
        end
        if (rd_acc) begin
            rptr_nxt = rptr + PTR_ONE;
        end
    end

    // rst_n is active-high in this block despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            data_out <= '0;
        end else begin
            wptr <= wptr_nxt;
            rptr <= rptr_nxt;
            if (rd_acc) begin
                data_out <= mem[rptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

`ifdef SYNC_FIFO_STATUS_EN
    logic [ADDR_WIDTH:0] count_nxt;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + PTR_ONE;
            2'b01:   count_nxt = count - PTR_ONE;
            default: count_nxt = count;
        endcase
    end

    // Overflow/underflow are sticky until reset so software can poll them late.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (wr_en && full && !rd_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// tb_sync_fifo_core: directed and randomized checks of sync_fifo_core against a queue-based model.
// Status-port checks are compiled in when SYNC_FIFO_STATUS_EN is defined.
module tb_sync_fifo_core;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
`ifdef SYNC_FIFO_STATUS_EN
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
`endif

    sync_fifo_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
`ifdef SYNC_FIFO_STATUS_EN
        ,
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO contents as a queue plus the last word read out.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] dout_m;
    logic          ovf_m;
    logic          udf_m;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(dout_m));
        check({tag, ".full"},     32'(full),     32'(model_q.size() == DEPTH));
        check({tag, ".empty"},    32'(empty),    32'(model_q.size() == 0));
`ifdef SYNC_FIFO_STATUS_EN
        check({tag, ".count"},     32'(count),     32'(model_q.size()));
        check({tag, ".overflow"},  32'(overflow),  32'(ovf_m));
        check({tag, ".underflow"}, 32'(underflow), 32'(udf_m));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check #1 later.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        logic was_full;
        logic was_empty;
        logic rd_ok;
        logic wr_ok;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        rd_ok     = r && !was_empty;
        wr_ok     = w && (!was_full || rd_ok);
        if (w && was_full && !rd_ok) ovf_m = 1'b1;
        if (r && was_empty) udf_m = 1'b1;
        if (rd_ok) dout_m = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst_n = 1'b1;
        #1;
        model_q.delete();
        dout_m = '0;
        ovf_m  = 1'b0;
        udf_m  = 1'b0;
        check_all(tag);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] prev;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        dout_m  = '0;
        ovf_m   = 1'b0;
        udf_m   = 1'b0;
        rst_n   = 1'b1;
        #3;
        do_reset("reset_init");

        // Reset mid-stream discards stored words at once.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom), "pre_reset_wr");
        do_reset("reset_mid");
        step(1'b0, 1'b1, 8'h00, "rd_after_reset");
        check("rd_after_reset.zero", 32'(data_out), 32'h0);

        // Fill and drain, including an ignored write while full.
        do_reset("reset_fill");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), "fill");
        check("fill.full_after_16", 32'(full), 32'h1);
        step(1'b1, 1'b0, 8'hAA, "wr_when_full");
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, "drain");
            check("drain.order", 32'(data_out), 32'(i));
        end
        check("drain.empty", 32'(empty), 32'h1);
        step(1'b0, 1'b1, 8'h00, "rd_when_empty");

        // Wrap-around: shift pointers by 10, then fill and drain across the wrap.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'($urandom), "wrap_pre_wr");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, "wrap_pre_rd");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(8'h20 + i), "wrap_fill");
        check("wrap.full", 32'(full), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, "wrap_drain");
            check("wrap.order", 32'(data_out), 32'(8'h20 + i));
        end

        // Simultaneous read and write at full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'($urandom), "sim_full_fill");
        step(1'b1, 1'b1, 8'h55, "sim_full");
        check("sim_full.full_stays", 32'(full), 32'h1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, "sim_full_drain");
        check("sim_full.last_is_55", 32'(data_out), 32'h55);

        // Simultaneous read and write at empty: the write wins, no bypass.
        prev = dout_m;
        step(1'b1, 1'b1, 8'h33, "sim_empty");
        check("sim_empty.dout_held", 32'(data_out), 32'(prev));
        check("sim_empty.not_empty", 32'(empty), 32'h0);
        step(1'b0, 1'b1, 8'h00, "sim_empty_rd");
        check("sim_empty.rd_33", 32'(data_out), 32'h33);

        // Randomized traffic with shifting write/read bias.
        for (int i = 0; i < 600; i++) begin
            int unsigned wbias;
            wbias = (i / 100) % 2 == 0 ? 70 : 30;
            step(($urandom % 100) < wbias, ($urandom % 100) < (100 - wbias),
                 DW'($urandom), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
